memory_arbiter: RTL

Shares the single RAM port between instruction fetch and data access in the single-cycle/pipelined MIPS datapath. Sits between the cache/request side (instruction read port, data read/write port) and the RAM model. It selects one requester with a registered grant, drives the RAM, and returns wait/load to the winner. It also aborts accesses that the RAM reports as failed or that exceed a cycle budget.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/arb_watchdog.sv | 28 ++
 rtl/memory_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM status, arbiter states, grant owner
// and the word returned to a requester whose access was aborted.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arbstate_t;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } grant_t;

    localparam logic [31:0] ARB_BAD_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/arb_watchdog.sv
// Saturating 8-bit cycle counter that flags an access which has been
// outstanding for TIMEOUT_CYCLES grant cycles.
module arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != 8'hFF)) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign expire_o = (count_q >= LIMIT);

endmodule

// File: rtl/memory_arbiter.sv
// Shares the single RAM port between instruction fetch and data access.
// Define ARB_RR_EN to alternate grants on contention; otherwise data always wins.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        arb_err
);
    arbstate_t state_q;
    logic      arb_err_q;

    logic i_req;
    logic d_req;
    logic req_live;
    logic complete;
    logic abort;
    logic withdraw;
    logic finish;
    logic wd_expire;
    logic pick_data;

    assign i_req = iREN;
    assign d_req = dREN | dWEN;

    always_comb begin
        case (state_q)
            IGRANT:  req_live = i_req;
            DGRANT:  req_live = d_req;
            default: req_live = 1'b0;
        endcase
    end

    // A RAM acknowledge in the same cycle as expiry still counts as completion.
    assign complete = req_live && (ramstate == ACCESS);
    assign abort    = req_live && !complete && ((ramstate == ERROR) || wd_expire);
    assign withdraw = (state_q != IDLE) && !req_live;
    assign finish   = complete || abort;

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .clr_i   (state_q == IDLE),
        .en_i    ((state_q != IDLE) && (ramstate != ACCESS)),
        .expire_o(wd_expire)
    );

`ifdef ARB_RR_EN
    grant_t last_grant_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_grant_q <= INSTR;
        end else if (finish) begin
            last_grant_q <= (state_q == DGRANT) ? DATA : INSTR;
        end
    end

    assign pick_data = d_req && (!i_req || (last_grant_q == INSTR));
`else
    assign pick_data = d_req;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            arb_err_q <= 1'b0;
        end else begin
            arb_err_q <= abort;
            case (state_q)
                IDLE: begin
                    if (pick_data) begin
                        state_q <= DGRANT;
                    end else if (i_req) begin
                        state_q <= IGRANT;
                    end
                end
                IGRANT, DGRANT: begin
                    if (finish || withdraw) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb_err = arb_err_q;

    // RAM side is driven straight from the granted port so a withdrawal
    // drops the strobes in the same cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = i_req;
        dwait    = d_req;
        iload    = '0;
        dload    = '0;
        case (state_q)
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iwait   = req_live && !finish;
                iload   = abort ? ARB_BAD_WORD : ramload;
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN && !dWEN;
                dwait    = req_live && !finish;
                dload    = abort ? ARB_BAD_WORD : ramload;
            end
            default: ;
        endcase
    end

endmodule
